servo_pulse_decoder: RTL and testbench
======================================

// Module: servo_pulse_decoder
// PURPOSE
//  Receive-side counterpart of the servo PWM generator: measures the high time of an incoming
//  servo pulse train (1 tick = 1 us at 1 MHz mclk, 20 ms frame) and recovers the commanded
//  width, an 8-bit position index (width/STEP_TICKS) and the 16-bit status word in the same
//  packed format the generator emits. Sits between a servo/feedback input pin and display/logging.
// PARAMETERS
//  FRAME_TICKS  20000  nominal frame length in mclk ticks
//  TOL_TICKS    2000   slack beyond FRAME_TICKS before frame loss is declared
//  MAX_TICKS    2200   largest legal pulse width; wider pulses flagged
//  STEP_TICKS   10     ticks per position step
//  FILT_TICKS   4      stability requirement when glitch filter compiled in
// PORTS
//  mclk         in   1   1 MHz system clock, all logic on rising edge
//  rst_n        in   1   synchronous reset, active-low
//  pwm_in       in   1   asynchronous servo pulse input
//  pulse_ticks  out  12  last accepted high width, ticks
//  position     out  8   floor(pulse_ticks/STEP_TICKS)
//  data_out     out  16  {2'b01,2'b00,position[7:4],2'b00,position[3:0],dir,hold}
//  valid        out  1   one-cycle strobe: pulse_ticks/position/data_out updated
//  err_width    out  1   one-cycle strobe: pulse rejected (width > MAX_TICKS)
//  frame_lost   out  1   level: no rising edge for FRAME_TICKS+TOL_TICKS ticks
// BEHAVIOUR
//  - Reset (rst_n=0 at an mclk edge): all outputs 0, state WAIT_LOW, counters 0.
//  - pwm_in passes a 2-flop synchronizer; edges detected on synchronized level.
//  - States: WAIT_LOW (discard partial pulse; ->WAIT_RISE when level 0),
//    WAIT_RISE (->HIGH on rise), HIGH (count width; ->LOW on fall), LOW (->HIGH on rise).
//  - 15-bit frame counter clears on every accepted rise, saturates at FRAME_TICKS+TOL_TICKS.
//  - Width counter 12-bit, saturating at 4095; width = number of mclk ticks sync level was 1.
//  - Position via step prescaler running during HIGH (increment every STEP_TICKS); remainder dropped.
//  - On fall: width<=MAX_TICKS -> outputs update, valid=1 on the cycle after the synchronized fall
//    (3 mclk after pin fall). Width>MAX_TICKS -> err_width=1 same cycle, outputs hold.
//  - dir=1 if new position > previous accepted position; hold=1 if equal; both 0 if lower.
//  - frame_lost sets when frame counter reaches FRAME_TICKS+TOL_TICKS in WAIT_RISE/LOW/HIGH
//    (stuck-high also counts); clears on next accepted rise. Outputs held while lost.
//  - Rise and fall never coincide on synchronized signal; reset wins over any event.
// CONFIGURATION
//  GLITCH_FILTER_EN defined: synchronized level must be stable FILT_TICKS consecutive ticks
//    before an edge is accepted; reported width unchanged (both edges delayed equally),
//    valid latency becomes 3+FILT_TICKS mclk after pin fall.
//  Undefined: every synchronized edge accepted; no filter logic instantiated.
// STRUCTURE
//  - Package servo_pkg: FRAME_TICKS/MAX_TICKS/STEP_TICKS defaults, state enum,
//    status-word header constants (2'b01, 2'b00), pack function {hdr,pos,dir,hold}.
//  - Sub-module servo_edge_sync: synchronizer, optional glitch filter, rise/fall strobes.
//  - Top: FSM, counters, prescaler, compare, output registers.
// TESTING
//  1 From reset, 1500-tick pulse, 20000 frame -> valid; pulse_ticks=1500, position=150,
//    data_out=16'h491A (dir=1).
//  2 Repeat 1500 -> data_out=16'h4919 (hold=1); 1495 next -> position=149, dir=0 hold=0.
//  3 2205-tick pulse -> err_width one cycle, valid=0, outputs keep previous values.
//  4 pwm_in held 0 after a rise -> frame_lost=1 exactly 22000 ticks after that rise;
//    clears on next rise, next pulse decodes normally.
//  5 rst_n=0 mid-pulse for 1 tick -> all outputs 0; remaining partial high ignored;
//    following full 1000-tick pulse -> position=100.
//  6 2-tick glitch: with GLITCH_FILTER_EN no valid/err; without -> valid, pulse_ticks=2, position=0.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants, FSM state type and status-word packing for the servo
// pulse decoder. Optional glitch filter macro: GLITCH_FILTER_EN.
package servo_pkg;

    localparam int FRAME_TICKS = 20000;
    localparam int TOL_TICKS   = 2000;
    localparam int MAX_TICKS   = 2200;
    localparam int STEP_TICKS  = 10;
    localparam int FILT_TICKS  = 4;

    localparam logic [1:0] HDR_HI = 2'b01;
    localparam logic [1:0] HDR_LO = 2'b00;

    typedef enum logic [1:0] {
        ST_WAIT_LOW,
        ST_WAIT_RISE,
        ST_HIGH,
        ST_LOW
    } state_e;

    // Same packed layout the PWM generator emits.
    function automatic logic [15:0] pack_status(
        input logic [7:0] pos,
        input logic       dir,
        input logic       hold
    );
        return {HDR_HI, HDR_LO, pos[7:4], 2'b00, pos[3:0], dir, hold};
    endfunction

endpackage

// File: rtl/servo_edge_sync.sv
// Synchronizes the servo pin, optionally debounces it (GLITCH_FILTER_EN),
// ports: mclk_i, pin_i in; level_o, rise_o, fall_o (1-cycle strobes) out.
module servo_edge_sync (
    input  logic mclk_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic lvl;
    logic prev_q;

    // The sync chain is deliberately not reset: a pulse already in flight
    // stays visible as a high level, so the FSM can discard it after reset.
    always_ff @(posedge mclk_i) begin
        s1_q <= pin_i;
        s2_q <= s1_q;
    end

`ifdef GLITCH_FILTER_EN
    import servo_pkg::*;

    localparam int FW = $clog2(FILT_TICKS + 1);
    localparam logic [FW-1:0] STAB_TOP = FW'(FILT_TICKS - 1);

    logic [FW-1:0] stab_q;
    logic          filt_q;

    // Level flips only after FILT_TICKS consecutive differing samples;
    // both edges see the same delay so the measured width is preserved.
    always_ff @(posedge mclk_i) begin
        if (s2_q == filt_q) begin
            stab_q <= '0;
        end else if (stab_q == STAB_TOP) begin
            filt_q <= s2_q;
            stab_q <= '0;
        end else begin
            stab_q <= stab_q + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = s2_q;
`endif

    always_ff @(posedge mclk_i) begin
        prev_q <= lvl;
    end

    assign level_o = lvl;
    assign rise_o  = lvl & ~prev_q;
    assign fall_o  = ~lvl & prev_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo pulse high time, reports width, position and status word.
// Ports: mclk,rst_n,pwm_in in; pulse_ticks,position,data_out,valid,err_width,frame_lost out. Macro: GLITCH_FILTER_EN.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int P_FRAME_TICKS = FRAME_TICKS,
    parameter int P_TOL_TICKS   = TOL_TICKS,
    parameter int P_MAX_TICKS   = MAX_TICKS,
    parameter int P_STEP_TICKS  = STEP_TICKS
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [11:0] pulse_ticks,
    output logic [7:0]  position,
    output logic [15:0] data_out,
    output logic        valid,
    output logic        err_width,
    output logic        frame_lost
);

    localparam int PW = $clog2(P_STEP_TICKS);
    localparam logic [PW-1:0] PRESC_TOP = PW'(P_STEP_TICKS - 1);
    localparam logic [14:0]   LOST_LIM  = 15'(P_FRAME_TICKS + P_TOL_TICKS);
    localparam logic [11:0]   MAX_W     = 12'(P_MAX_TICKS);

    logic level;
    logic rise;
    logic fall;

    servo_edge_sync u_sync (
        .mclk_i  (mclk),
        .pin_i   (pwm_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_e        state_q, state_d;
    logic [11:0]   width_q, width_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [14:0]   frame_q, frame_d;
    logic [11:0]   pulse_q, pulse_d;
    logic [7:0]    pos_q, pos_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          lost_q, lost_d;
    logic          rise_acc;

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_LOW;
            width_q <= '0;
            presc_q <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            pulse_q <= '0;
            pos_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            pulse_q <= pulse_d;
            pos_q   <= pos_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        pulse_d  = pulse_q;
        pos_d    = pos_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        lost_d   = lost_q;
        rise_acc = 1'b0;

        if (frame_q != LOST_LIM) begin
            frame_d = frame_q + 15'd1;
        end

        unique case (state_q)
            ST_WAIT_LOW: begin
                if (!level) begin
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE, ST_LOW: begin
                if (rise) begin
                    state_d  = ST_HIGH;
                    rise_acc = 1'b1;
                    // The rise cycle is the first high tick.
                    width_d  = 12'd1;
                    presc_d  = PW'(1);
                    cnt_d    = '0;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d = ST_LOW;
                    if (!lost_q) begin
                        if (width_q <= MAX_W) begin
                            pulse_d = width_q;
                            pos_d   = cnt_q;
                            data_d  = pack_status(cnt_q, cnt_q > pos_q,
                                                  cnt_q == pos_q);
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else begin
                    if (width_q != 12'hFFF) begin
                        width_d = width_q + 12'd1;
                    end
                    // cnt tracks floor(width/STEP) as the pulse runs.
                    if (presc_q == PRESC_TOP) begin
                        presc_d = '0;
                        if (cnt_q != 8'hFF) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
        endcase

        if (rise_acc) begin
            frame_d = '0;
            lost_d  = 1'b0;
        end else if (state_q != ST_WAIT_LOW && frame_d == LOST_LIM) begin
            lost_d = 1'b1;
        end
    end

    assign pulse_ticks = pulse_q;
    assign position    = pos_q;
    assign data_out    = data_q;
    assign valid       = valid_q;
    assign err_width   = err_q;
    assign frame_lost  = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Self-checking bench for servo_pulse_decoder: vector table, corner
// sequences and random pulses against a behavioural width model.
module tb_servo_pulse_decoder;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic [11:0] pulse_ticks;
    logic [7:0]  position;
    logic [15:0] data_out;
    logic        valid;
    logic        err_width;
    logic        frame_lost;

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc++;

    servo_pulse_decoder dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .pulse_ticks (pulse_ticks),
        .position    (position),
        .data_out    (data_out),
        .valid       (valid),
        .err_width   (err_width),
        .frame_lost  (frame_lost)
    );

`ifdef GLITCH_FILTER_EN
    localparam int LAT  = 7;
    localparam int FILT = 4;
`else
    localparam int LAT  = 3;
`endif

    int n_run  = 0;
    int n_fail = 0;

    int          last_pos = 0;
    logic [11:0] m_ticks  = '0;
    logic [7:0]  m_pos    = '0;
    logic [15:0] m_data   = '0;

    typedef struct {
        int          w;
        logic        err;
        logic [11:0] ticks;
        logic [7:0]  pos;
        logic [15:0] data;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: accepted pulse -> width, width/10, dir/hold vs last one.
    task automatic model_pulse(input int w, output logic [11:0] evm,
                               output logic [11:0] eem);
        int pos;
        evm = '0;
        eem = '0;
`ifdef GLITCH_FILTER_EN
        if (w < FILT) return;
`endif
        if (w > 2200) begin
            eem[LAT-1] = 1'b1;
            return;
        end
        pos     = w / 10;
        m_ticks = 12'(w);
        m_pos   = 8'(pos);
        m_data  = 16'h4000 | 16'((pos / 16) << 8) | 16'((pos % 16) << 2)
                | (pos > last_pos ? 16'd2 : 16'd0)
                | (pos == last_pos ? 16'd1 : 16'd0);
        last_pos = pos;
        evm[LAT-1] = 1'b1;
    endtask

    task automatic finish_pulse(input int w, input int pre,
                                output logic [11:0] vm,
                                output logic [11:0] em);
        repeat (w - pre) @(negedge mclk);
        pwm_in = 1'b0;
        vm = '0;
        em = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge mclk);
            vm[k] = valid;
            em[k] = err_width;
        end
    endtask

    task automatic check_pulse(input string tag, input int w,
                               input logic [11:0] vm,
                               input logic [11:0] em);
        logic [11:0] evm;
        logic [11:0] eem;
        model_pulse(w, evm, eem);
        chk({tag, " valid"}, vm, evm);
        chk({tag, " err"}, em, eem);
        chk({tag, " ticks"}, pulse_ticks, m_ticks);
        chk({tag, " pos"}, position, m_pos);
        chk({tag, " data"}, data_out, m_data);
    endtask

    task automatic send(input string tag, input int w, input int gap,
                        output logic [11:0] em);
        logic [11:0] vm;
        @(negedge mclk);
        pwm_in = 1'b1;
        finish_pulse(w, 0, vm, em);
        check_pulse(tag, w, vm, em);
        repeat (gap) @(negedge mclk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ticks"}, pulse_ticks, 0);
        chk({tag, " pos"}, position, 0);
        chk({tag, " data"}, data_out, 0);
        chk({tag, " valid"}, valid, 0);
        chk({tag, " err"}, err_width, 0);
        chk({tag, " lost"}, frame_lost, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] vm;
        logic [11:0] em;
        int          t0;
        int          w;

        tbl[0] = '{1500, 1'b0, 12'd1500, 8'd150, 16'h491A};
        tbl[1] = '{1500, 1'b0, 12'd1500, 8'd150, 16'h4919};
        tbl[2] = '{1495, 1'b0, 12'd1495, 8'd149, 16'h4914};
        tbl[3] = '{2205, 1'b1, 12'd1495, 8'd149, 16'h4914};
        tbl[4] = '{1000, 1'b0, 12'd1000, 8'd100, 16'h4610};
        tbl[5] = '{2200, 1'b0, 12'd2200, 8'd220, 16'h4D32};
        tbl[6] = '{2201, 1'b1, 12'd2200, 8'd220, 16'h4D32};
        tbl[7] = '{9,    1'b0, 12'd9,    8'd0,   16'h4000};
        tbl[8] = '{10,   1'b0, 12'd10,   8'd1,   16'h4006};
        tbl[9] = '{4095, 1'b1, 12'd10,   8'd1,   16'h4006};

        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge mclk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge mclk);

        for (int i = 0; i < 10; i++) begin
            send($sformatf("vec%0d", i), tbl[i].w, 30, em);
            chk($sformatf("vec%0d tbl_err", i), |em, tbl[i].err);
            chk($sformatf("vec%0d tbl_ticks", i), pulse_ticks, tbl[i].ticks);
            chk($sformatf("vec%0d tbl_pos", i), position, tbl[i].pos);
            chk($sformatf("vec%0d tbl_data", i), data_out, tbl[i].data);
        end

        // Frame loss: pin held low after one pulse.
        @(negedge mclk);
        pwm_in = 1'b1;
        t0 = cyc;
        finish_pulse(1500, 0, vm, em);
        check_pulse("fl_pulse", 1500, vm, em);
        while (cyc < t0 + LAT + 21999) @(negedge mclk);
        chk("fl_before", frame_lost, 0);
        @(negedge mclk);
        chk("fl_set", frame_lost, 1);
        repeat (50) @(negedge mclk);
        chk("fl_hold_data", data_out, m_data);
        @(negedge mclk);
        pwm_in = 1'b1;
        repeat (LAT - 1) @(negedge mclk);
        chk("fl_still", frame_lost, 1);
        @(negedge mclk);
        chk("fl_clear", frame_lost, 0);
        finish_pulse(800, LAT, vm, em);
        check_pulse("fl_recover", 800, vm, em);
        repeat (30) @(negedge mclk);

        // One-tick reset in the middle of a pulse.
        @(negedge mclk);
        pwm_in = 1'b1;
        repeat (300) @(negedge mclk);
        rst_n = 1'b0;
        @(negedge mclk);
        rst_n = 1'b1;
        chk_zero("midrst");
        finish_pulse(700, 301, vm, em);
        chk("midrst partial valid", vm, 0);
        chk("midrst partial err", em, 0);
        last_pos = 0;
        m_ticks  = '0;
        m_pos    = '0;
        m_data   = '0;
        repeat (30) @(negedge mclk);
        send("after_rst", 1000, 30, em);
        chk("after_rst pos100", position, 100);
        chk("after_rst data", data_out, 16'h4612);

        // Two-tick glitch.
        send("glitch", 2, 30, em);
`ifndef GLITCH_FILTER_EN
        chk("glitch ticks2", pulse_ticks, 2);
        chk("glitch pos0", position, 0);
`endif

        for (int i = 0; i < 20; i++) begin
            w = int'($urandom_range(1, 2400));
            send($sformatf("rnd%0d", i), w, int'($urandom_range(5, 60)), em);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
